// File: rtl/bist_pattern_source.sv
// BIST stimulus source: drives counter or LFSR patterns to a gate-under-test and
// compacts the sampled responses into a serial signature plus a ones count.
module bist_pattern_source #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     LFSR_TAPS = 'hB8,
  parameter logic [WIDTH-1:0]     LFSR_SEED = 'h01,
  parameter int unsigned          SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY  = 'h1021
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH:0]       count,
  output logic [WIDTH-1:0]     pat_out,
  output logic                 pat_valid,
  input  logic                 pat_ready,
  input  logic                 resp_in,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [WIDTH:0]       ones_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW = WIDTH + 1;
  // A zero seed would lock the LFSR at zero forever.
  localparam logic [WIDTH-1:0] SEED_EFF = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [CW-1:0]        remain_q, remain_d;
  logic [WIDTH-1:0]     gen_q, gen_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [CW-1:0]        ones_q, ones_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fire;
  logic [WIDTH-1:0]     lfsr_next;

  assign fire      = valid_q & pat_ready;
  assign lfsr_next = (gen_q >> 1) ^ (gen_q[0] ? LFSR_TAPS : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      remain_q <= '0;
      gen_q    <= '0;
      sig_q    <= '0;
      ones_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      remain_q <= remain_d;
      gen_q    <= gen_d;
      sig_q    <= sig_d;
      ones_q   <= ones_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    remain_d = remain_q;
    gen_d    = gen_q;
    sig_d    = sig_q;
    ones_d   = ones_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d   = mode;
          remain_d = count;
          gen_d    = mode ? SEED_EFF : '0;
          sig_d    = '0;
          ones_d   = '0;
          state_d  = (count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Everything advances only on an accepted pattern; otherwise hold.
        if (fire) begin
          sig_d    = {sig_q[SIG_WIDTH-2:0], 1'b0}
                   ^ ((sig_q[SIG_WIDTH-1] ^ resp_in) ? SIG_POLY : '0);
          ones_d   = ones_q + CW'(resp_in);
          gen_d    = mode_q ? lfsr_next : gen_q + WIDTH'(1);
          remain_d = remain_q - CW'(1);
          if (remain_q == CW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  assign pat_out   = gen_q;
  assign pat_valid = valid_q;
  assign signature = sig_q;
  assign ones_cnt  = ones_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/bist_pattern_source.md
Name: bist_pattern_source

Overview:
On-chip stimulus source and response compactor for fault-simulation benches. It sits directly upstream of a combinational gate-under-test, such as the 8-input NAND macro. It drives WIDTH-bit patterns onto the gate inputs and samples the gate's 1-bit output on the same handshake. It also accumulates a serial signature and a ones count, so a run can be compared against a golden value instead of being logged pattern-by-pattern.

Parameters:
WIDTH, 8, pattern width (matches gate input bus)
LFSR_TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1, period 255)
LFSR_SEED, 8'h01, LFSR start value; a zero seed is replaced by 1
SIG_WIDTH, 16, signature register width
SIG_POLY, 16'h1021, signature feedback polynomial

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a run (sampled in IDLE and DONE only)
mode  input  1  0 = exhaustive up-counter, 1 = LFSR; captured at start
count  input  WIDTH+1  number of patterns in the run; captured at start
pat_out  output  WIDTH  pattern to gate-under-test
pat_valid  output  1  pat_out is valid
pat_ready  input  1  consumer accepts pattern this cycle
resp_in  input  1  gate output for current pat_out
signature  output  SIG_WIDTH  compacted response
ones_cnt  output  WIDTH+1  number of accepted patterns with resp_in=1
busy  output  1  run in progress
done  output  1  run complete, results stable

Behaviour:
- Reset (async assert, sync release) drives the block to IDLE and clears every output:
  - pat_out=0, pat_valid=0, signature=0, ones_cnt=0, busy=0, done=0.
- State IDLE:
  - Outputs idle.
  - On start=1: capture mode and count, load generator (0 for counter mode, seed for LFSR mode), clear signature and ones_cnt.
  - If count==0, go to DONE; otherwise go to RUN.
- State RUN:
  - busy=1 and pat_valid=1 are registered, asserted the cycle after start is seen.
  - fire = pat_valid & pat_ready.
  - On fire:
    - signature <= {signature[SIG_WIDTH-2:0],0} ^ (signature[MSB]^resp_in ? SIG_POLY : 0).
    - ones_cnt += resp_in.
    - Generator advances: counter +1 (wraps mod 2^WIDTH); LFSR <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
    - Remaining count decrements.
  - On the fire that takes remaining from 1 to 0, go to DONE.
  - With no fire (pat_ready=0), pat_out is held stable and no state changes. The response is sampled only on fire.
  - start is ignored in RUN.
- State DONE:
  - done=1, busy=0, pat_valid=0.
  - signature, ones_cnt and pat_out are held.
  - start=1 behaves as in IDLE: a new run begins and done drops the next cycle.
- Latency and throughput: first pattern is valid 1 cycle after start. With pat_ready held high the run is one pattern per cycle, so done asserts count+1 cycles after start.
- LFSR mode never emits 0. count greater than 255 in LFSR mode repeats the sequence.
- Counter mode with count=2^WIDTH covers all patterns exactly once.
- Reset mid-run aborts immediately: all outputs return to reset values and no partial results are retained.
- mode and count changes during RUN have no effect.

Test Plan:
- Counter mode, count=256, pat_ready=1, NAND DUT on resp_in: pat_out steps 00..FF. done asserts 257 cycles after start and ones_cnt=255.
- LFSR mode, seed 01, count=6: pat_out sequence is 01, B8, 5C, 2E, 17, B3. With count=255 and the NAND DUT, ones_cnt=254 and pat_out never equals 00.
- count=1, resp_in=1, counter mode: signature=16'h1021, ones_cnt=1, done asserts 2 cycles after start.
- Backpressure: hold pat_ready=0 for 5 cycles mid-run. pat_out and signature stay stable, and they match a run with pat_ready=1 apart from timing.
- count=0: done=1 the cycle after start, pat_valid never asserts, signature=0.
- Assert rst during RUN after 10 patterns: all outputs go to 0 asynchronously. A subsequent start re-runs from the initial pattern with cleared signature.
